pipelined_mac_pe: RTL and testbench

//  Multi-lane, pipelined signed MAC processing element for the iEEG inference datapath.

---
 rtl/pipelined_mac_pe.sv | 206 ++++++++++++++++++++
 tb/tb_pipelined_mac_pe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_mac_pe.sv
// pipelined_mac_pe
//   Multi-lane signed multiply-accumulate element. One dot product covers
//   cfg_len+1 input beats of LANES activation/weight pairs. The products of a
//   beat are summed and registered (stage 1), then added into a saturating
//   accumulator (stage 2). After the last beat has drained, the element shows
//   the accumulator and a rounded, right-shifted, saturated requantised value
//   on a valid/ready output port.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   en                global enable; low freezes all state (abort/rst_n still act)
//   start, abort      begin a dot product (IDLE only) / synchronous abort
//   cfg_len, cfg_shift beats-1 and requant shift, latched on accepted start
//   in_valid/in_ready input beat handshake; in_mask, act, wgt beat payload
//   out_valid/out_ready result handshake; out_acc, out_q, out_ovf result
//   busy              high whenever the FSM is not IDLE
//   fsm_state         current FSM state encoding, for observation
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. Ready never depends on valid, and the
// payload of the output port is held constant while out_valid is high.

module pipelined_mac_pe #(
    parameter int DW_A  = 8,
    parameter int DW_W  = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 22,
    parameter int LEN_W = 10,
    parameter int SH_W  = 5,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     start,
    input  logic                     abort,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [SH_W-1:0]          cfg_shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_mask,
    input  logic [LANES*DW_A-1:0]    act,
    input  logic [LANES*DW_W-1:0]    wgt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic signed [OUT_W-1:0]  out_q,
    output logic                     out_ovf,
    output logic                     busy,
    output logic [1:0]               fsm_state
);

    // Full-precision width of one beat's lane sum.
    localparam int PW = DW_A + DW_W + $clog2(LANES);

    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                    state;
    logic [LEN_W-1:0]          len_r;
    logic [LEN_W-1:0]          count;
    logic [SH_W-1:0]           shift_r;
    logic                      p_v;
    logic signed [ACC_W-1:0]   p_sum;
    logic signed [ACC_W-1:0]   acc;
    logic                      ovf;

    logic                      accept;
    logic signed [DW_A+DW_W-1:0] prod;
    logic signed [PW-1:0]      lane_sum;
    logic signed [ACC_W:0]     acc_wide;
    logic signed [ACC_W-1:0]   acc_sat;
    logic                      acc_clamp;
    logic signed [ACC_W-1:0]   acc_fin;
    logic                      ovf_fin;
    logic signed [ACC_W:0]     rq_ext;
    logic signed [ACC_W:0]     rq_rnd;
    logic signed [ACC_W:0]     rq_r;
    logic signed [OUT_W-1:0]   q_next;

    assign in_ready  = en & (state == S_ACC);
    assign out_valid = en & (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;
    assign accept    = in_valid & in_ready;

    // Beat lane sum; masked lanes have their operands forced to zero.
    always_comb begin
        lane_sum = '0;
        prod     = '0;
        for (int i = 0; i < LANES; i++) begin
            prod     = (in_mask[i] ? $signed(act[i*DW_A +: DW_A]) : $signed({DW_A{1'b0}}))
                     * (in_mask[i] ? $signed(wgt[i*DW_W +: DW_W]) : $signed({DW_W{1'b0}}));
            lane_sum = lane_sum + PW'(prod);
        end
    end

    // Saturating accumulate: one guard bit, clamp when it disagrees with the sign.
    always_comb begin
        acc_wide  = {acc[ACC_W-1], acc} + {p_sum[ACC_W-1], p_sum};
        acc_clamp = (acc_wide[ACC_W] != acc_wide[ACC_W-1]);
        if (acc_clamp)
            acc_sat = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_sat = acc_wide[ACC_W-1:0];
        acc_fin = p_v ? acc_sat : acc;
        ovf_fin = ovf | (p_v & acc_clamp);
    end

    // Requantise the final accumulator: round half up, arithmetic shift,
    // ACC_W+1 bits wide, then clamp into the signed OUT_W range.
    always_comb begin
        rq_ext = {acc_fin[ACC_W-1], acc_fin};
        rq_rnd = (ACC_W+1)'(1) << (shift_r - 1'b1);
        if (shift_r == '0)
            rq_r = rq_ext;
        else
            rq_r = (rq_ext + rq_rnd) >>> shift_r;
        if (rq_r > Q_MAX)
            q_next = Q_MAX[OUT_W-1:0];
        else if (rq_r < Q_MIN)
            q_next = Q_MIN[OUT_W-1:0];
        else
            q_next = rq_r[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_r   <= '0;
            count   <= '0;
            shift_r <= '0;
            p_v     <= 1'b0;
            p_sum   <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            out_acc <= '0;
            out_q   <= '0;
            out_ovf <= 1'b0;
        end else if (abort) begin
            // Abort drops any in-flight work; the held result registers are untouched
            // but out_valid cannot rise because the FSM returns to IDLE.
            state <= S_IDLE;
            p_v   <= 1'b0;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            // Stage 1: register the beat sum at acceptance.
            p_v <= accept;
            if (accept)
                p_sum <= ACC_W'(lane_sum);

            // Stage 2: fold the previous beat into the accumulator.
            if (p_v) begin
                acc <= acc_sat;
                if (acc_clamp)
                    ovf <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ACC;
                        len_r   <= cfg_len;
                        shift_r <= cfg_shift;
                        count   <= '0;
                        acc     <= '0;
                        ovf     <= 1'b0;
                        out_acc <= '0;
                        out_q   <= '0;
                        out_ovf <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (count == len_r)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last beat is being accumulated this cycle; capture the
                    // final values so they are stable for the whole OUT phase.
                    state   <= S_OUT;
                    out_acc <= acc_fin;
                    out_q   <= q_next;
                    out_ovf <= ovf_fin;
                end
                S_OUT: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_mac_pe.sv
// tb_pipelined_mac_pe
//   Table-driven vectors with a result scoreboard, random dot products checked
//   against a small arithmetic model, and hand sequences for enable freeze,
//   output back-pressure, abort and asynchronous reset.

module tb_pipelined_mac_pe;

    localparam int ACC_W = 22;
    localparam int OUT_W = 8;
    localparam int LANES = 4;
    localparam int EW    = ACC_W + OUT_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              en = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [9:0]        cfg_len = '0;
    logic [4:0]        cfg_shift = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [LANES-1:0]  in_mask = '0;
    logic [31:0]       act = '0;
    logic [31:0]       wgt = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_acc;
    logic signed [OUT_W-1:0] out_q;
    logic              out_ovf;
    logic              busy;
    logic [1:0]        fsm_state;

    always #5 clk = ~clk;

    pipelined_mac_pe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .act       (act),
        .wgt       (wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_q     (out_q),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    typedef struct {
        int          len;
        int          sh;
        logic [3:0]  mask;
        logic [31:0] a;
        logic [31:0] w;
        int          e_acc;
        int          e_q;
        bit          e_ovf;
    } vec_t;

    vec_t           tbl[12];
    logic [EW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_pass   = 0;

    task automatic check(input string name, input longint got, input longint req);
        n_checks++;
        if (got == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, required %0d", name, got, req);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    task automatic push_exp(input int e_acc, input int e_q, input bit e_ovf);
        exp_q.push_back({e_ovf, ACC_W'(e_acc), OUT_W'(e_q)});
    endtask

    task automatic compare_out(input string name);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            fail_now({name, "_sb_empty"});
        end else begin
            e = exp_q.pop_front();
            check({name, "_acc"}, longint'(out_acc), longint'($signed(e[EW-2:OUT_W])));
            check({name, "_q"},   longint'(out_q),   longint'($signed(e[OUT_W-1:0])));
            check({name, "_ovf"}, longint'(out_ovf), longint'(e[EW-1]));
        end
    endtask

    // Called just after a falling edge; leaves the bench just after a falling edge.
    task automatic start_dot(input int len, input int sh);
        start     = 1'b1;
        cfg_len   = 10'(len);
        cfg_shift = 5'(sh);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beats(input int len, input logic [3:0] m, input logic [31:0] a,
                              input logic [31:0] w, input bit gaps);
        int guard;
        for (int b = 0; b <= len; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (b == 1) begin
                    // Enable low with a valid beat offered: nothing may transfer.
                    en       = 1'b0;
                    in_valid = 1'b1;
                    in_mask  = m;
                    act      = a;
                    wgt      = w;
                    #1;
                    check("freeze_in_ready", longint'(in_ready), 0);
                    repeat (3) @(negedge clk);
                    en = 1'b1;
                end
            end
            in_valid = 1'b1;
            in_mask  = m;
            act      = a;
            wgt      = w;
            #1;
            guard = 0;
            while (!in_ready && guard < 16) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready)
                fail_now("in_ready_timeout");
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Entered one falling edge after the last accepted beat (the DRAIN cycle).
    task automatic finish_dot(input string name);
        int guard;
        check({name, "_drain_valid"}, longint'(out_valid), 0);
        @(negedge clk);
        check({name, "_latency"}, longint'(out_valid), 1);
        guard = 0;
        while (!out_valid && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (out_valid)
            compare_out(name);
        else
            fail_now({name, "_out_timeout"});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle_busy"}, longint'(busy), 0);
        check({name, "_idle_valid"}, longint'(out_valid), 0);
    endtask

    task automatic run_vec(input vec_t v, input string name, input bit gaps);
        push_exp(v.e_acc, v.e_q, v.e_ovf);
        start_dot(v.len, v.sh);
        send_beats(v.len, v.mask, v.a, v.w, gaps);
        finish_dot(name);
    endtask

    function automatic vec_t model_vec(input int len, input int sh, input logic [3:0] m,
                                       input logic [31:0] a, input logic [31:0] w);
        vec_t   v;
        longint beat;
        longint s;
        longint r;
        logic [7:0] ab;
        logic [7:0] wb;
        beat = 0;
        for (int i = 0; i < LANES; i++) begin
            ab = a[i*8 +: 8];
            wb = w[i*8 +: 8];
            if (m[i])
                beat += longint'($signed(ab)) * longint'($signed(wb));
        end
        s = beat * (len + 1);
        if (sh == 0) r = s;
        else         r = (s + (longint'(1) << (sh - 1))) >>> sh;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        v.len = len; v.sh = sh; v.mask = m; v.a = a; v.w = w;
        v.e_acc = int'(s); v.e_q = int'(r); v.e_ovf = 1'b0;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        tbl[0]  = '{3,    0, 4'hF, 32'h01010101, 32'h02020202,      32,   32, 1'b0};
        tbl[1]  = '{31,   0, 4'hF, 32'h80808080, 32'h80808080, 2097151,  127, 1'b1};
        tbl[2]  = '{0,    3, 4'h1, 32'h00000025, 32'h00000001,      37,    5, 1'b0};
        tbl[3]  = '{0,    3, 4'h1, 32'h000000DB, 32'h00000001,     -37,   -5, 1'b0};
        tbl[4]  = '{0,    1, 4'h1, 32'h00000064, 32'h00000003,     300,  127, 1'b0};
        tbl[5]  = '{0,    0, 4'h1, 32'h09090903, 32'h02020202,       6,    6, 1'b0};
        tbl[6]  = '{32,   0, 4'hF, 32'h80808080, 32'h7F7F7F7F, -2097152, -128, 1'b1};
        tbl[7]  = '{0,    4, 4'h1, 32'h00000008, 32'h00000001,       8,    1, 1'b0};
        tbl[8]  = '{0,    4, 4'h1, 32'h000000F8, 32'h00000001,      -8,    0, 1'b0};
        tbl[9]  = '{1023, 5, 4'hF, 32'h01010101, 32'h01010101,    4096,  127, 1'b0};
        tbl[10] = '{2,    0, 4'h0, 32'h7F7F7F7F, 32'h7F7F7F7F,       0,    0, 1'b0};
        tbl[11] = '{1,    2, 4'hF, 32'h01FE03FC, 32'h05050505,     -20,   -5, 1'b0};

        // Reset.
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  longint'(in_ready),  0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy",      longint'(busy),      0);
        check("rst_out_acc",   longint'(out_acc),   0);
        check("rst_out_q",     longint'(out_q),     0);
        check("rst_out_ovf",   longint'(out_ovf),   0);
        check("rst_state",     longint'(fsm_state), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check("idle_in_ready", longint'(in_ready), 0);

        // Table vectors.
        for (int i = 0; i < 12; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // Random vectors against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            v = model_vec($urandom_range(0, 7), $urandom_range(0, 8), 4'($urandom_range(0, 15)),
                          $urandom, $urandom);
            run_vec(v, $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
        end

        // In_valid gaps and a 3-cycle enable freeze mid-accumulation.
        run_vec(tbl[0], "gaps", 1'b1);
        v = tbl[5];
        v.len = 3;
        v.e_acc = 24;
        v.e_q = 24;
        run_vec(v, "gaps_mask", 1'b1);

        // Output back-pressure: outputs hold, no input ready, start ignored.
        push_exp(32, 32, 1'b0);
        start_dot(3, 0);
        send_beats(3, 4'hF, 32'h01010101, 32'h02020202, 1'b0);
        check("hold_drain_valid", longint'(out_valid), 0);
        @(negedge clk);
        check("hold_latency", longint'(out_valid), 1);
        compare_out("hold");
        start   = 1'b1;
        cfg_len = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k),    longint'(out_valid), 1);
            check($sformatf("hold%0d_acc", k),      longint'(out_acc),   32);
            check($sformatf("hold%0d_q", k),        longint'(out_q),     32);
            check($sformatf("hold%0d_in_ready", k), longint'(in_ready),  0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release_busy", longint'(busy), 0);
        @(negedge clk);
        check("hold_start_ignored", longint'(busy), 0);

        // Abort after two of four beats.
        start_dot(3, 0);
        send_beats(1, 4'hF, 32'h01010101, 32'h02020202, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_in_ready", longint'(in_ready), 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("abort_no_valid%0d", k), longint'(out_valid), 0);
            @(negedge clk);
        end
        run_vec(tbl[0], "post_abort", 1'b0);

        // Asynchronous reset while a result is being offered.
        start_dot(3, 0);
        send_beats(3, 4'hF, 32'h01010101, 32'h02020202, 1'b0);
        @(negedge clk);
        check("prerst_valid", longint'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid",   longint'(out_valid), 0);
        check("midrst_busy",    longint'(busy),      0);
        check("midrst_out_acc", longint'(out_acc),   0);
        check("midrst_out_q",   longint'(out_q),     0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(tbl[11], "post_rst", 1'b0);

        check("sb_drained", longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
